// File: rtl/lsu_ctrl.sv
// Load/store unit controller sitting between the execute stage and data_mem.
// One request is accepted per handshake, screened for funct3 legality,
// alignment and address range, and (if clean) given a single-cycle data_mem
// access. Every accepted request produces exactly one response.
//
// Handshake rules: a transfer on either interface happens on a rising edge
// where valid and ready are both 1. req_ready is 1 only in IDLE; once
// rsp_valid rises, rsp_rdata/rsp_err/rsp_code hold their values until the
// edge where rsp_ready is 1. The producer may not withdraw or alter a
// request while valid is high and ready is low.
module lsu_ctrl #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    // request side (execute stage)
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [N-1:0]      req_addr,
    input  logic [N-1:0]      req_wdata,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        rsp_code,
    // data_mem side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_funct3,
    output logic [N-1:0]      mem_wdata,
    input  logic [N-1:0]      mem_rdata,
    // FSM state for observation: 0 IDLE, 1 ACCESS, 2 RESP
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_ALIGN = 2'b01;
    localparam logic [1:0] CODE_RANGE = 2'b10;
    localparam logic [1:0] CODE_ILL   = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;

    // latched request
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [N-1:0]        r_wdata;

    // registered response
    logic [N-1:0]        r_rsp_rdata;
    logic                r_rsp_err;
    logic [1:0]          r_rsp_code;

    // classification of the incoming request
    logic [ADDR_W:0]     w_size_m1;
    logic [ADDR_W:0]     w_end;
    logic                w_illegal;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_fault;
    logic [1:0]          w_code;

    // Classify the request on the input pins so the verdict lands in the accept edge.
    always_comb begin
        w_size_m1      = '0;
        w_illegal      = 1'b0;
        w_misaligned   = 1'b0;
        w_out_of_range = 1'b0;
        w_code         = CODE_OK;

        // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word
        case (req_funct3[1:0])
            2'b01:   w_size_m1 = (ADDR_W+1)'(1);
            2'b10:   w_size_m1 = (ADDR_W+1)'(3);
            default: w_size_m1 = '0;
        endcase

        // Stores allow only SB/SH/SW; loads reject 011 and the unsigned-word/11x slots.
        if (req_we) begin
            w_illegal = (req_funct3 > 3'b010);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end

        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        // Last byte touched must still sit inside data_mem; one spare bit catches the wrap.
        w_end          = {1'b0, req_addr[ADDR_W-1:0]} + w_size_m1;
        w_out_of_range = (req_addr[N-1:ADDR_W] != '0) ||
                         (w_end > {1'b0, {ADDR_W{1'b1}}});

        // Priority: illegal funct3, then alignment, then range.
        if (w_illegal) begin
            w_code = CODE_ILL;
        end else if (w_misaligned) begin
            w_code = CODE_ALIGN;
        end else if (w_out_of_range) begin
            w_code = CODE_RANGE;
        end else begin
            w_code = CODE_OK;
        end
    end

    assign w_fault = (w_code != CODE_OK);

    // State register; async reset drops straight to IDLE, which also kills the strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and data_mem drive; strobes and bus values exist only in ACCESS.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_funct3 = 3'b000;
        mem_wdata  = '0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    // Faulting requests bypass memory entirely.
                    w_next   = w_fault ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_read   = ~r_we;
                mem_write  = r_we;
                mem_addr   = r_addr;
                mem_funct3 = r_funct3;
                mem_wdata  = r_wdata;
                w_next     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch and response registers; load data is captured at the end of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_code  <= CODE_OK;
        end else if (w_accept) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr[ADDR_W-1:0];
            r_wdata     <= req_wdata;
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_fault;
            r_rsp_code  <= w_code;
        end else if (r_state == S_ACCESS) begin
            // Stores report zero data; loads take data_mem's already-extended word.
            r_rsp_rdata <= r_we ? '0 : mem_rdata;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign rsp_code  = r_rsp_code;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a small byte-array data_mem model with combinational,
// sign/zero-extending reads, a strobe monitor, and a queue of expected
// responses ({err, code, rdata}) pushed as each request is driven.
module tb_lsu_ctrl;

    localparam int N  = 32;
    localparam int AW = 6;
    localparam int W  = N + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [N-1:0]  req_addr;
    logic [N-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_rdata;
    logic          rsp_err;
    logic [1:0]    rsp_code;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_funct3;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;
    logic [1:0]    dbg_state;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [W-1:0]  exp_q[$];

    // memory model and preload port
    logic [7:0]    mem [0:63];
    logic          pl_en = 1'b0;
    logic [5:0]    pl_addr = '0;
    logic [7:0]    pl_data = '0;
    logic [5:0]    a0, a1, a2, a3;

    // strobe monitor
    int            rd_cnt   = 0;
    int            wr_cnt   = 0;
    int            both_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [2:0]    last_f3   = '0;

    always #5 clk = ~clk;

    lsu_ctrl #(.N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_code(rsp_code),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // data_mem read: little-endian, extension chosen by funct3
    always_comb begin
        a0 = mem_addr;
        a1 = mem_addr + 6'd1;
        a2 = mem_addr + 6'd2;
        a3 = mem_addr + 6'd3;
        mem_rdata = '0;
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
            3'b001:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b010:  mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
            3'b100:  mem_rdata = {24'h0, mem[a0]};
            3'b101:  mem_rdata = {16'h0, mem[a1], mem[a0]};
            default: mem_rdata = '0;
        endcase
    end

    // data_mem write plus bench preload
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_write) begin
            mem[a0] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[a1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_read)  begin rd_cnt++; last_addr = mem_addr; last_f3 = mem_funct3; end
        if (mem_write) begin wr_cnt++; last_addr = mem_addr; last_f3 = mem_funct3; end
        if (mem_read && mem_write) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Presents a request at a falling edge, holds it through one rising edge.
    task automatic send_req(input logic we, input logic [2:0] f3,
                            input logic [N-1:0] addr, input logic [N-1:0] wdata,
                            output logic accepted, output time t_acc);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        accepted = req_ready;
        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid = 1'b0;
    endtask

    // Counts falling edges after the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(output int lat, output logic [W-1:0] got, output logic timeout);
        lat = 0; timeout = 1'b1; got = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                timeout = 1'b0;
                got = {rsp_err, rsp_code, rsp_rdata};
                break;
            end
        end
    endtask

    task automatic run_one(input logic we, input logic [2:0] f3,
                           input logic [N-1:0] addr, input logic [N-1:0] wdata,
                           output logic acc, output int lat, output logic [W-1:0] got,
                           output logic to, output time t_acc);
        send_req(we, f3, addr, wdata, acc, t_acc);
        wait_rsp(lat, got, to);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, rsp_code, mem_read, mem_write, dbg_state} !== 9'b1_0_0_00_0_0_00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b err=%b code=%b rd=%b wr=%b st=%0d",
                     req_ready, rsp_valid, rsp_err, rsp_code, mem_read, mem_write, dbg_state);
        end
        vectors++;
        if ({rsp_rdata, mem_addr, mem_funct3, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h maddr=%h mf3=%b mwdata=%h expected all 0",
                     rsp_rdata, mem_addr, mem_funct3, mem_wdata);
        end
    endtask

    task automatic test_load_word();
        logic acc, to; int lat; logic [W-1:0] got, exp; time t; int rd0, wr0;
        preload(6'd8, 8'hDE); preload(6'd9, 8'hAD); preload(6'd10, 8'hBE); preload(6'd11, 8'hEF);
        rd0 = rd_cnt; wr0 = wr_cnt;
        exp_q.push_back({1'b0, 2'b00, 32'hEFBE_ADDE});
        run_one(1'b0, 3'b010, 32'd8, 32'h0, acc, lat, got, to, t);
        exp = exp_q.pop_front();
        vectors++;
        if (acc !== 1'b1 || to) begin miscompares++; $display("FAIL lw8_handshake: acc=%b timeout=%b expected acc=1 timeout=0", acc, to); end
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL lw8_data: got %h expected %h", got, exp); end
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL lw8_latency: got %0d expected 2", lat); end
        vectors++;
        if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0 || last_addr !== 6'd8) begin
            miscompares++;
            $display("FAIL lw8_strobes: reads=%0d writes=%0d addr=%0d expected 1 0 8", rd_cnt - rd0, wr_cnt - wr0, last_addr);
        end
    endtask

    task automatic test_store_byte();
        logic acc, to; int lat; logic [W-1:0] got, exp; time t; int rd0, wr0;
        preload(6'd4, 8'h11); preload(6'd5, 8'h00); preload(6'd6, 8'h22);
        rd0 = rd_cnt; wr0 = wr_cnt;
        exp_q.push_back({1'b0, 2'b00, 32'h0});
        run_one(1'b1, 3'b000, 32'd5, 32'h1234_56A7, acc, lat, got, to, t);
        exp = exp_q.pop_front();
        vectors++;
        if (acc !== 1'b1 || to || got !== exp || lat !== 2) begin
            miscompares++;
            $display("FAIL sb5_rsp: acc=%b to=%b got %h lat %0d expected %h lat 2", acc, to, got, lat, exp);
        end
        vectors++;
        if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0 || last_f3 !== 3'b000 || last_addr !== 6'd5) begin
            miscompares++;
            $display("FAIL sb5_strobes: writes=%0d reads=%0d f3=%b addr=%0d expected 1 0 000 5",
                     wr_cnt - wr0, rd_cnt - rd0, last_f3, last_addr);
        end
        vectors++;
        if ({mem[4], mem[5], mem[6]} !== 24'h11A722) begin
            miscompares++;
            $display("FAIL sb5_mem: got %h%h%h expected 11a722", mem[4], mem[5], mem[6]);
        end
        exp_q.push_back({1'b0, 2'b00, 32'h0000_00A7});
        run_one(1'b0, 3'b100, 32'd5, 32'h0, acc, lat, got, to, t);
        exp = exp_q.pop_front();
        vectors++;
        if (to || got !== exp) begin miscompares++; $display("FAIL lbu5: got %h expected %h", got, exp); end
        exp_q.push_back({1'b0, 2'b00, 32'hFFFF_FFA7});
        run_one(1'b0, 3'b000, 32'd5, 32'h0, acc, lat, got, to, t);
        exp = exp_q.pop_front();
        vectors++;
        if (to || got !== exp) begin miscompares++; $display("FAIL lb5: got %h expected %h", got, exp); end
    endtask

    task automatic test_faults();
        logic acc, to; int lat; logic [W-1:0] got, exp; time t; int rd0, wr0;
        // {we, funct3, addr, expected code}; SW 62 is misaligned, which outranks range
        logic [37:0] tbl [0:9];
        tbl[0] = {1'b0, 3'b001, 32'd3,          2'b01};
        tbl[1] = {1'b1, 3'b010, 32'd62,         2'b01};
        tbl[2] = {1'b0, 3'b010, 32'd64,         2'b10};
        tbl[3] = {1'b1, 3'b000, 32'd64,         2'b10};
        tbl[4] = {1'b1, 3'b010, 32'h1000_0000,  2'b10};
        tbl[5] = {1'b0, 3'b101, 32'd63,         2'b01};
        tbl[6] = {1'b1, 3'b100, 32'd1,          2'b11};
        tbl[7] = {1'b0, 3'b011, 32'd0,          2'b11};
        tbl[8] = {1'b0, 3'b111, 32'd70,         2'b11};
        tbl[9] = {1'b1, 3'b011, 32'd2,          2'b11};
        for (int i = 0; i < 10; i++) begin
            rd0 = rd_cnt; wr0 = wr_cnt;
            exp_q.push_back({1'b1, tbl[i][1:0], 32'h0});
            run_one(tbl[i][37], tbl[i][36:34], tbl[i][33:2], 32'hCAFE_F00D, acc, lat, got, to, t);
            exp = exp_q.pop_front();
            vectors++;
            if (acc !== 1'b1 || to || got !== exp) begin
                miscompares++;
                $display("FAIL fault%0d_rsp: acc=%b to=%b got %h expected %h", i, acc, to, got, exp);
            end
            vectors++;
            if (lat !== 1) begin miscompares++; $display("FAIL fault%0d_latency: got %0d expected 1", i, lat); end
            @(negedge clk);
            vectors++;
            if (rd_cnt != rd0 || wr_cnt != wr0) begin
                miscompares++;
                $display("FAIL fault%0d_strobes: reads=%0d writes=%0d expected 0 0", i, rd_cnt - rd0, wr_cnt - wr0);
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc, to; int lat; logic [W-1:0] got, exp; time t; int rd0, wr0;
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 2'b00, 32'hEFBE_ADDE});
        run_one(1'b0, 3'b010, 32'd8, 32'h0, acc, lat, got, to, t);
        exp = exp_q.pop_front();
        vectors++;
        if (acc !== 1'b1 || to || got !== exp) begin
            miscompares++;
            $display("FAIL bp_rsp: acc=%b to=%b got %h expected %h", acc, to, got, exp);
        end
        rd0 = rd_cnt; wr0 = wr_cnt;
        // offer a store while the response is stalled; it must be ignored
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd0; req_wdata = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_err, rsp_code, rsp_rdata} !== exp) begin
                miscompares++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b rsp=%h expected 1 0 %h",
                         i, rsp_valid, req_ready, {rsp_err, rsp_code, rsp_rdata}, exp);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== 2'd0 ||
            rd_cnt != rd0 || wr_cnt != wr0) begin
            miscompares++;
            $display("FAIL bp_release: rdy=%b vld=%b st=%0d reads=%0d writes=%0d expected 1 0 0 0 0",
                     req_ready, rsp_valid, dbg_state, rd_cnt - rd0, wr_cnt - wr0);
        end
        exp_q.push_back({1'b0, 2'b00, 32'h0000_00DE});
        run_one(1'b0, 3'b100, 32'd8, 32'h0, acc, lat, got, to, t);
        exp = exp_q.pop_front();
        vectors++;
        if (acc !== 1'b1 || to || got !== exp) begin
            miscompares++;
            $display("FAIL bp_next: acc=%b to=%b got %h expected %h", acc, to, got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, to; int lat; logic [W-1:0] got, exp; time t, t_prev;
        logic [5:0] a; logic [7:0] b0, b1, b2, b3;
        for (int i = 16; i < 32; i++) preload(6'(i), 8'(i) ^ 8'h5A);
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 6'(16 + 4 * $urandom_range(0, 3));
                b0 = 8'(a) ^ 8'h5A; b1 = 8'(a + 6'd1) ^ 8'h5A;
                b2 = 8'(a + 6'd2) ^ 8'h5A; b3 = 8'(a + 6'd3) ^ 8'h5A;
                exp_q.push_back({1'b0, 2'b00, b3, b2, b1, b0});
                run_one(1'b0, 3'b010, 32'(a), 32'h0, acc, lat, got, to, t);
            end else begin
                a = 6'($urandom_range(16, 31));
                b0 = 8'(a) ^ 8'h5A;
                exp_q.push_back({1'b0, 2'b00, 24'h0, b0});
                run_one(1'b0, 3'b100, 32'(a), 32'h0, acc, lat, got, to, t);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (acc !== 1'b1 || to || got !== exp || lat !== 2) begin
                miscompares++;
                $display("FAIL b2b%0d: addr=%0d acc=%b to=%b got %h lat %0d expected %h lat 2",
                         i, a, acc, to, got, lat, exp);
            end
            if (i > 0) begin
                vectors++;
                if (t - t_prev !== 30) begin
                    miscompares++;
                    $display("FAIL b2b%0d_spacing: got %0t expected 30", i, t - t_prev);
                end
            end
            t_prev = t;
        end
    endtask

    task automatic test_reset_mid();
        logic acc, to; int lat; logic [W-1:0] got, exp; time t;
        preload(6'd0, 8'h01); preload(6'd1, 8'h02); preload(6'd2, 8'h03); preload(6'd3, 8'h04);
        send_req(1'b1, 3'b010, 32'd0, 32'hFFFF_FFFF, acc, t);
        vectors++;
        if (acc !== 1'b1 || mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_access: acc=%b wr=%b expected 1 1", acc, mem_write);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || dbg_state !== 2'd0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_drop: wr=%b rd=%b st=%0d vld=%b expected 0 0 0 0",
                     mem_write, mem_read, dbg_state, rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h0403_0201) begin
            miscompares++;
            $display("FAIL rstmid_mem: got %h%h%h%h expected 04030201", mem[3], mem[2], mem[1], mem[0]);
        end
        wait_rsp(lat, got, to);
        vectors++;
        if (!to || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_no_rsp: response seen=%b queue=%0d expected 0 0", !to, exp_q.size());
        end
        exp_q.push_back({1'b0, 2'b00, 32'h0403_0201});
        run_one(1'b0, 3'b010, 32'd0, 32'h0, acc, lat, got, to, t);
        exp = exp_q.pop_front();
        vectors++;
        if (acc !== 1'b1 || to || got !== exp) begin
            miscompares++;
            $display("FAIL rstmid_recover: acc=%b to=%b got %h expected %h", acc, to, got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_faults();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (both_cnt != 0) begin
            miscompares++;
            $display("FAIL strobe_exclusive: both asserted %0d times expected 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
